// File: rtl/bus_wait_pkg.sv
// Shared types and widths for the 6502 bus wait-state controller.
package bus_wait_pkg;

    localparam int REGION_W = 2;
    localparam int WS_W     = 4;
    localparam int TMO_W    = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        EXT  = 2'd2
    } state_t;

    function automatic logic [3:0] region_cs(input logic [REGION_W-1:0] r);
        region_cs = 4'b0001 << r;
    endfunction

endpackage

// File: rtl/wait_counter.sv
// Loadable counter: saturating down-count for wait states, free up-count for timers.
module wait_counter #(
    parameter int W  = 4,
    parameter bit UP = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         zero
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en) begin
            if (UP)
                cnt <= cnt + W'(1);
            else if (cnt != '0)
                cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/bus_wait_ctl.sv
// Region-decoded RDY stretcher for 6502 read cycles, with optional external ACK wait.
// Define BUS_WAIT_TIMEOUT_EN to bound the EXT_ACK wait and report BUS_ERR.
module bus_wait_ctl
    import bus_wait_pkg::*;
#(
    parameter logic [WS_W-1:0]  WS0      = 4'd0,
    parameter logic [WS_W-1:0]  WS1      = 4'd0,
    parameter logic [WS_W-1:0]  WS2      = 4'd2,
    parameter logic [WS_W-1:0]  WS3      = 4'd1,
    parameter logic [3:0]       EXT_MASK = 4'b1000,
    parameter logic [TMO_W-1:0] TIMEOUT  = 8'd64
) (
    input  logic        PHI0,
    input  logic        RES,
    input  logic [15:0] ADDR,
    input  logic        RnW,
    input  logic        EXT_ACK,
    output logic        RDY,
    output logic [3:0]  CS,
    output logic        BUSY,
    output logic        BUS_ERR
);

    state_t                state, state_nx;
    logic [REGION_W-1:0]   region, r_l;
    logic [WS_W-1:0]       ws_cur, cnt_init, unused_ws_cnt;
    logic                  ext_cur, ext_l;
    logic                  cnt_load, cnt_dec, cnt_zero;
    logic                  tmo;
    logic                  rdy_c;

    function automatic logic [WS_W-1:0] ws_of(input logic [REGION_W-1:0] r);
        case (r)
            2'd0:    ws_of = WS0;
            2'd1:    ws_of = WS1;
            2'd2:    ws_of = WS2;
            default: ws_of = WS3;
        endcase
    endfunction

    assign region   = ADDR[15:14];
    assign ws_cur   = ws_of(region);
    assign ext_cur  = EXT_MASK[region];
    assign ext_l    = EXT_MASK[r_l];
    assign cnt_init = ws_cur - 4'd1;

    wait_counter #(.W(WS_W), .UP(1'b0)) u_ws_cnt (
        .clk      (PHI0),
        .rst      (RES),
        .load     (cnt_load),
        .load_val (cnt_init),
        .en       (cnt_dec),
        .cnt      (unused_ws_cnt),
        .zero     (cnt_zero)
    );

`ifdef BUS_WAIT_TIMEOUT_EN
    logic [TMO_W-1:0] tmr;
    logic             tmr_clr, unused_tmr_zero;

    assign tmr_clr = (state != EXT) && (state_nx == EXT);

    wait_counter #(.W(TMO_W), .UP(1'b1)) u_tmo_cnt (
        .clk      (PHI0),
        .rst      (RES),
        .load     (tmr_clr),
        .load_val ('0),
        .en       (state == EXT),
        .cnt      (tmr),
        .zero     (unused_tmr_zero)
    );

    assign tmo = (state == EXT) && (tmr == TIMEOUT - 8'd1);
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge PHI0 or posedge RES) begin
        if (RES)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Region is captured only when a read actually begins stalling.
    always_ff @(posedge PHI0 or posedge RES) begin
        if (RES)
            r_l <= '0;
        else if (state == IDLE && state_nx != IDLE)
            r_l <= region;
    end

    always_comb begin
        state_nx = state;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        case (state)
            IDLE: begin
                if (RnW) begin
                    if (ws_cur != '0) begin
                        cnt_load = 1'b1;
                        state_nx = WAIT;
                    end else if (ext_cur && !EXT_ACK) begin
                        state_nx = EXT;
                    end
                end
            end
            WAIT: begin
                if (cnt_zero)
                    state_nx = ext_l ? EXT : IDLE;
                else
                    cnt_dec = 1'b1;
            end
            EXT: begin
                if (EXT_ACK || tmo)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        rdy_c = 1'b1;
        case (state)
            IDLE: begin
                if (RnW) begin
                    if (ws_cur != '0)
                        rdy_c = 1'b0;
                    else if (ext_cur)
                        rdy_c = EXT_ACK;
                end
            end
            WAIT:    rdy_c = cnt_zero & ~ext_l;
            EXT:     rdy_c = EXT_ACK | tmo;
            default: rdy_c = 1'b1;
        endcase
    end

    // RES overrides asynchronously so the core is released at once.
    assign RDY     = RES | rdy_c;
    assign CS      = RES ? 4'b0000 : region_cs((state == IDLE) ? region : r_l);
    assign BUSY    = (state != IDLE);
    assign BUS_ERR = ~RES & tmo & ~EXT_ACK;

endmodule
